// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - pin-side and conditioned-output bundle for input_conditioner
interface input_conditioner_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] toggle;
  logic             any_event;

  modport master (
    output raw_in,
    input  level, rise, fall, toggle, any_event
  );

  modport slave (
    input  raw_in,
    output level, rise, fall, toggle, any_event
  );
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchroniser, debounce counter, edge pulses and toggle state
module input_conditioner #(
  parameter int               WIDTH         = 4,
  parameter int               STABLE_CYCLES = 50000,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   io
);
  localparam int               CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] toggle_q, toggle_d;
  logic             any_event_q, any_event_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_LEVEL;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level_q     <= RESET_LEVEL;
      rise_q      <= '0;
      fall_q      <= '0;
      toggle_q    <= '0;
      any_event_q <= 1'b0;
    end else begin
      sync_q[0] <= io.raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      toggle_q    <= toggle_d;
      any_event_q <= any_event_d;
    end
  end

  // cnt == 0 with s == level is the idle state; any disagreement counts toward acceptance
  always_comb begin
    level_d  = level_q;
    toggle_d = toggle_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == LAST) begin
          level_d[i] = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
          if (s[i]) toggle_d[i] = ~toggle_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_event_d = |(rise_d | fall_d);
  end

  assign io.level     = level_q;
  assign io.rise      = rise_q;
  assign io.fall      = fall_q;
  assign io.toggle    = toggle_q;
  assign io.any_event = any_event_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner against a sliding-window model
module tb_input_conditioner;
  localparam int W  = 4;
  localparam int SC = 8;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_conditioner_if #(.WIDTH(W)) io ();

  input_conditioner #(
    .WIDTH(W), .STABLE_CYCLES(SC), .SYNC_STAGES(SS), .RESET_LEVEL(4'b0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int checks   = 0;
  int failures = 0;

  // Model: a channel flips when its last SC post-reset synchronised samples all disagree with the level
  logic [W-1:0] m_level  = '0;
  logic [W-1:0] m_rise   = '0;
  logic [W-1:0] m_fall   = '0;
  logic [W-1:0] m_toggle = '0;
  logic         m_any    = 1'b0;
  logic [W-1:0] raw_q [$];
  logic [W-1:0] s_q   [$];

  always @(posedge clk) begin
    logic [W-1:0] sp;
    bit           all_diff;
    if (rst) begin
      raw_q.delete();
      s_q.delete();
      m_level = '0; m_rise = '0; m_fall = '0; m_toggle = '0; m_any = 1'b0;
    end else begin
      raw_q.push_back(io.raw_in);
      sp = (raw_q.size() > SS) ? raw_q[raw_q.size()-1-SS] : 4'b0000;
      s_q.push_back(sp);
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (s_q.size() >= SC) begin
          all_diff = 1'b1;
          for (int j = 0; j < SC; j++)
            if (s_q[s_q.size()-1-j][i] == m_level[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[i] = ~m_level[i];
            if (m_level[i]) begin
              m_rise[i]   = 1'b1;
              m_toggle[i] = ~m_toggle[i];
            end else begin
              m_fall[i] = 1'b1;
            end
          end
        end
      end
      m_any = |(m_rise | m_fall);
      if (raw_q.size() > 32) void'(raw_q.pop_front());
      if (s_q.size() > 32) void'(s_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int rise_edge = -1;
    @(negedge clk);
    rst = 1'b1;
    io.raw_in = 4'b1111;
    #1;
    checks++;
    if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== 17'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", {io.level, io.rise, io.fall, io.toggle, io.any_event});
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== 17'h0) begin
        failures++;
        $display("FAIL reset_hold e=%0d got=%h exp=0", e, {io.level, io.rise, io.fall, io.toggle, io.any_event});
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL reset_model e=%0d got=%h exp=%h", e,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
      if (io.rise == 4'b1111) rise_edge = e;
    end
    checks++;
    if (rise_edge != 10 || io.level !== 4'b1111 || io.toggle !== 4'b1111) begin
      failures++;
      $display("FAIL reset_release rise_edge=%0d level=%b toggle=%b exp 10 1111 1111", rise_edge, io.level, io.toggle);
    end
  endtask

  task automatic test_clean_step;
    int rise_edge = -1, fall_edge = -1, any_edge = -1;
    logic [W-1:0] tog0;
    io.raw_in = 4'b0000;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL clean_settle e=%0d got=%h exp=%h", e,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
    end
    tog0 = io.toggle;
    io.raw_in = 4'b0001;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL clean_rise_model e=%0d got=%h exp=%h", e,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
      if (io.rise[0]) rise_edge = e;
      if (io.any_event) any_edge = e;
    end
    checks++;
    if (rise_edge != 10 || any_edge != 10 || io.level[0] !== 1'b1 || io.toggle[0] !== ~tog0[0]) begin
      failures++;
      $display("FAIL clean_rise rise_edge=%0d any_edge=%0d level0=%b toggle0=%b exp 10 10 1 %b",
               rise_edge, any_edge, io.level[0], io.toggle[0], ~tog0[0]);
    end
    tog0 = io.toggle;
    io.raw_in = 4'b0000;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL clean_fall_model e=%0d got=%h exp=%h", e,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
      if (io.fall[0]) fall_edge = e;
    end
    checks++;
    if (fall_edge != 10 || io.level[0] !== 1'b0 || io.toggle !== tog0) begin
      failures++;
      $display("FAIL clean_fall fall_edge=%0d level0=%b toggle=%b exp 10 0 %b", fall_edge, io.level[0], io.toggle, tog0);
    end
  endtask

  task automatic test_bounce;
    int pulses = 0, rise_edge = -1, settle_pulses = 0;
    for (int c = 0; c < 60; c++) begin
      io.raw_in = {2'b00, ((c / 3) % 2 == 0), 1'b0};
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL bounce_model c=%0d got=%h exp=%h", c,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
      if (io.rise[1] || io.fall[1]) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL bounce_quiet pulses=%0d exp=0", pulses);
    end
    io.raw_in = 4'b0010;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (io.rise[1]) begin
        rise_edge = e;
        settle_pulses++;
      end
    end
    checks++;
    if (rise_edge != 10 || settle_pulses != 1 || io.level[1] !== 1'b1) begin
      failures++;
      $display("FAIL bounce_settle rise_edge=%0d pulses=%0d level1=%b exp 10 1 1", rise_edge, settle_pulses, io.level[1]);
    end
  endtask

  task automatic test_boundary;
    int rises, falls;
    for (int len = SC - 1; len <= SC; len++) begin
      rises = 0;
      falls = 0;
      io.raw_in = 4'b0110;
      for (int e = 1; e <= 30; e++) begin
        if (e == len + 1) io.raw_in = 4'b0010;
        tick();
        checks++;
        if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
          failures++;
          $display("FAIL boundary_model len=%0d e=%0d got=%h exp=%h", len, e,
                   {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
        end
        if (io.rise[2]) rises++;
        if (io.fall[2]) falls++;
      end
      checks++;
      if (rises != (len == SC ? 1 : 0) || falls != rises) begin
        failures++;
        $display("FAIL boundary_len len=%0d rises=%0d falls=%0d exp %0d", len, rises, falls, (len == SC ? 1 : 0));
      end
    end
  endtask

  task automatic test_simultaneous;
    int ev_cycles = 0, rise_cycles = 0;
    logic [W-1:0] tog0, seen = '0;
    io.raw_in = 4'b0000;
    for (int e = 0; e < 20; e++) tick();
    tog0 = io.toggle;
    io.raw_in = 4'b1010;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL simul_model e=%0d got=%h exp=%h", e,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
      if (io.any_event) ev_cycles++;
      if (io.rise != 4'b0000) begin
        rise_cycles++;
        seen = io.rise;
      end
    end
    checks++;
    if (ev_cycles != 1 || rise_cycles != 1 || seen !== 4'b1010 || io.toggle !== (tog0 ^ 4'b1010)) begin
      failures++;
      $display("FAIL simul_pulse ev=%0d rc=%0d rise=%b toggle=%b exp 1 1 1010 %b",
               ev_cycles, rise_cycles, seen, io.toggle, tog0 ^ 4'b1010);
    end
  endtask

  task automatic test_reset_mid;
    int rise_edge = -1, early = 0;
    io.raw_in = 4'b0000;
    for (int e = 0; e < 20; e++) tick();
    io.raw_in = 4'b1000;
    for (int e = 1; e <= SS + 5; e++) tick();
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      if (io.rise != 4'b0000 || io.any_event) early++;
    end
    checks++;
    if (early != 0 || io.level[3] !== 1'b0) begin
      failures++;
      $display("FAIL midreset_hold pulses=%0d level3=%b exp 0 0", early, io.level[3]);
    end
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL midreset_model e=%0d got=%h exp=%h", e,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
      if (io.rise[3]) rise_edge = e;
    end
    checks++;
    if (rise_edge != 10) begin
      failures++;
      $display("FAIL midreset_release rise_edge=%0d exp=10", rise_edge);
    end
  endtask

  task automatic test_random;
    int hold [W];
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          io.raw_in[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 14));
        end else begin
          hold[i]--;
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if ({io.level, io.rise, io.fall, io.toggle, io.any_event} !== {m_level, m_rise, m_fall, m_toggle, m_any}) begin
        failures++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c,
                 {io.level, io.rise, io.fall, io.toggle, io.any_event}, {m_level, m_rise, m_fall, m_toggle, m_any});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    io.raw_in = 4'b0000;
    test_reset();
    test_clean_step();
    test_bounce();
    test_boundary();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel conditioner for asynchronous board inputs such as slide switches and push buttons. It is the input-side counterpart of the LED and counter outputs on the board top level. Each channel is synchronised into the system clock domain, debounced with a per-channel stability counter, and presented as a clean level plus one-cycle rise/fall pulses and a toggle state. The block sits between the raw pins and all control logic, including clock-select, video mode selection and test LEDs.

## Interface
- WIDTH, 4: number of independent input channels (1..32).
- STABLE_CYCLES, 50000: consecutive clock cycles a synchronised input must differ from the current level before the level changes. Minimum 1. The default is 1 ms at 50 MHz.
- SYNC_STAGES, 2: flip-flops in each synchroniser chain (2..4).
- RESET_LEVEL, all-zero [WIDTH-1:0]: value loaded into the synchronisers and `level` at reset.
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- raw_in  input  WIDTH  asynchronous pin inputs, one bit per channel.
- level  output  WIDTH  debounced level per channel.
- rise  output  WIDTH  one-cycle pulse when `level` goes 0→1.
- fall  output  WIDTH  one-cycle pulse when `level` goes 1→0.
- toggle  output  WIDTH  flips on every `rise` of its channel.
- any_event  output  1  OR of all `rise` and `fall` bits, same cycle.

## Operation
- Per channel, `raw_in[i]` passes through a SYNC_STAGES flip-flop chain. The last stage is `s[i]`. No logic is placed between chain stages.
- Per channel counter `cnt[i]`, width clog2(STABLE_CYCLES+1), unsigned. Never wraps.
- Each edge, when `s[i] == level[i]`: `cnt[i] <= 0`. No output change.
- Each edge, when `s[i] != level[i]` and `cnt[i] < STABLE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
- Each edge, when `s[i] != level[i]` and `cnt[i] == STABLE_CYCLES-1`, the following happen together:
  - `level[i] <= s[i]`
  - `cnt[i] <= 0`
  - `rise[i]` or `fall[i]` <= 1, according to the new level
  - on rise only, `toggle[i] <= ~toggle[i]`
- `rise` and `fall` are registered and high for exactly one cycle per accepted transition. They are never both high on the same channel.
- Any return of `s[i]` to `level[i]` before acceptance clears `cnt[i]`. The discarded bounce produces no pulse.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle. `any_event` is high in that cycle.
- Effective two-state FSM per channel:
  - STABLE: `cnt == 0`, `s == level`.
  - PENDING: `s != level`, counting.
  - PENDING → STABLE on acceptance or on a bounce back.

## Timing
- Reset (asynchronous assert, effective immediately):
  - synchronisers and `level` = RESET_LEVEL
  - `cnt` = 0
  - `rise`, `fall`, `toggle`, `any_event` = 0
- Reset mid-PENDING aborts the pending transition. No pulse is generated.
- After reset release, an input that differs from RESET_LEVEL is debounced normally and then produces a pulse.
- Latency: number rising edges from the first edge that samples a new stable `raw_in` value as edge 1.
  - `level`, `rise`/`fall`, `toggle` and `any_event` update on edge SYNC_STAGES+STABLE_CYCLES.
  - The pulse is visible for the one cycle following that edge.
- Glitch rejection: any excursion of `s` lasting fewer than STABLE_CYCLES consecutive cycles is ignored.
- With STABLE_CYCLES=1, `level` follows `s` one edge later.
- A new opposite transition can begin counting on the cycle immediately after an acceptance. Minimum spacing between pulses on one channel is STABLE_CYCLES cycles.

## Test plan
Bench configuration: WIDTH=4, STABLE_CYCLES=8, SYNC_STAGES=2, RESET_LEVEL=4'b0000.

- **Reset values.** Assert rst while raw_in=4'b1111 → all outputs 0 during reset. After release, `level` reaches 4'b1111 and `rise`=4'b1111 for one cycle on edge 10 after release; `toggle`=4'b1111.
- **Clean step.** raw_in[0] 0→1 held → `level[0]` and a one-cycle `rise[0]` on edge 10; `any_event`=1 that cycle. Later 1→0 → one `fall[0]` on edge 10; `toggle[0]` unchanged by the fall.
- **Bounce rejection.** raw_in[1] toggles every 3 cycles for 60 cycles, then settles at 1 → no pulse during bouncing. Exactly one `rise[1]` arrives 10 edges after the final settle.
- **Boundary length.** raw_in[2] high for exactly 7 synchronised cycles → no change. High for exactly 8 → `level[2]`=1 and one `rise[2]`.
- **Simultaneous channels.** raw_in 4'b0000→4'b1010 on the same edge → `rise`=4'b1010 in one cycle, a single `any_event` cycle, and `toggle` bits 1 and 3 flip.
- **Reset mid-operation.** raw_in[3] goes high; rst asserted at cycle 5 of counting for 2 cycles → no pulse during reset; `level[3]`=0. After release, `rise[3]` on edge 10 after release.
